mem_stage: RTL and testbench

Memory-access stage directly downstream of the execute stage. It captures the execute stage's address, byte enables, store data and load-type flags, then drives one request on the data-memory SRAM-like req/addr_ok/data_ok interface. It holds the pipeline with MEM_busy until the transaction completes, then aligns and extends load data (LB/LBU/LH/LHU/LW/LWL/LWR) and presents the result to write-back. Non-memory instructions pass through in one cycle.

---
 rtl/mem_stage_pkg.sv | 35 +++
 rtl/mem_stage_if.sv | 30 +++
 rtl/mem_stage_load_align.sv | 66 ++++++
 rtl/mem_stage.sv | 157 +++++++++++++++
 tb/tb_mem_stage.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared types and constants for the memory-access stage:
//               FSM state encoding, load-type vector indices, kseg masking.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    CANCEL = 2'd3
  } state_t;

  // Bit positions inside the packed load-type vector
  localparam int LT_LB  = 0;
  localparam int LT_LBU = 1;
  localparam int LT_LH  = 2;
  localparam int LT_LHU = 3;
  localparam int LT_LW  = 4;
  localparam int LT_LWL = 5;
  localparam int LT_LWR = 6;
  localparam int LT_W   = 7;

  // kseg0/kseg1 map onto the low 512 MB of physical space
  localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

  function automatic logic is_kseg(input logic [31:0] vaddr);
    return (vaddr[31:30] == 2'b10);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_if
// Description : SRAM-like data-memory bus (req / addr_ok / data_ok).
//               master = pipeline memory stage, slave = memory / bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if;

  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational load-data alignment, sign/zero extension and
//               LWL/LWR merge with the old rt value.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
  import mem_stage_pkg::*;
(
  input  wire logic [31:0]     rdata,
  input  wire logic [31:0]     rt,
  input  wire logic [1:0]      a,
  input  wire logic [LT_W-1:0] load_type,
  output logic      [31:0]     result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] lwl_val;
  logic [31:0] lwr_val;

  // Lane selection, merge patterns and final result selection
  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    lwl_val  = 32'h0;
    lwr_val  = 32'h0;
    result   = 32'h0;

    case (a)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase

    half_sel = a[1] ? rdata[31:16] : rdata[15:0];

    // LWL fills the high bytes from memory, keeps low bytes of rt
    case (a)
      2'd0: lwl_val = {rdata[7:0],  rt[23:0]};
      2'd1: lwl_val = {rdata[15:0], rt[15:0]};
      2'd2: lwl_val = {rdata[23:0], rt[7:0]};
      default: lwl_val = rdata;
    endcase

    // LWR fills the low bytes from memory, keeps high bytes of rt
    case (a)
      2'd0: lwr_val = rdata;
      2'd1: lwr_val = {rt[31:24], rdata[31:8]};
      2'd2: lwr_val = {rt[31:16], rdata[31:16]};
      default: lwr_val = {rt[31:8], rdata[31:24]};
    endcase

    if (load_type[LT_LB])       result = {{24{byte_sel[7]}}, byte_sel};
    else if (load_type[LT_LBU]) result = {24'h0, byte_sel};
    else if (load_type[LT_LH])  result = {{16{half_sel[15]}}, half_sel};
    else if (load_type[LT_LHU]) result = {16'h0, half_sel};
    else if (load_type[LT_LW])  result = rdata;
    else if (load_type[LT_LWL]) result = lwl_val;
    else if (load_type[LT_LWR]) result = lwr_val;
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Pipeline memory-access stage. Captures one instruction from
//               execute, issues at most one data-memory request, holds the
//               pipeline until completion and presents the aligned result.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter bit ADDR_MASK_KSEG = 1'b1
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        MEM_stall,
  input  wire logic        MEM_clear,
  input  wire logic        EXE_valid,
  input  wire logic        EXE_load,
  input  wire logic        EXE_store,
  input  wire logic        EXE_LB,
  input  wire logic        EXE_LBU,
  input  wire logic        EXE_LH,
  input  wire logic        EXE_LHU,
  input  wire logic        EXE_LW,
  input  wire logic        EXE_LWL,
  input  wire logic        EXE_LWR,
  input  wire logic [31:0] EXE_alu_result,
  input  wire logic [3:0]  EXE_mem_wen,
  input  wire logic [31:0] EXE_mem_wdata,
  input  wire logic [31:0] EXE_vsrc2,
  input  wire logic [4:0]  EXE_dest,
  input  wire logic        EXE_goto_WB,
  input  wire logic [31:0] EXE_pc,
  input  wire logic        EXE_exc_any,
  mem_stage_if.master      dbus,
  output logic             MEM_busy,
  output logic             MEM_valid,
  output logic [31:0]      MEM_result,
  output logic [4:0]       MEM_dest,
  output logic             MEM_goto_WB,
  output logic [31:0]      MEM_pc
);

  state_t            state;
  state_t            state_nx;
  logic              valid_r;
  logic [31:0]       pc_r;
  logic [4:0]        dest_r;
  logic              goto_wb_r;
  logic [31:0]       addr_r;
  logic [31:0]       wdata_r;
  logic [3:0]        wen_r;
  logic              store_r;
  logic [LT_W-1:0]   ltype_r;
  logic [31:0]       vsrc2_r;
  logic [31:0]       result_r;
  logic [31:0]       align_result;
  logic [LT_W-1:0]   exe_ltype;
  logic              capture;

  assign exe_ltype = {EXE_LWR, EXE_LWL, EXE_LW, EXE_LHU, EXE_LH, EXE_LBU, EXE_LB};
  assign MEM_busy  = (state != IDLE);
  assign capture   = EXE_valid && !MEM_busy && !MEM_stall && !MEM_clear;

  load_align u_align (
    .rdata     (dbus.data_rdata),
    .rt        (vsrc2_r),
    .a         (addr_r[1:0]),
    .load_type (ltype_r),
    .result    (align_result)
  );

  // State register plus pipeline capture and load-result update
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      valid_r   <= 1'b0;
      pc_r      <= 32'h0;
      dest_r    <= 5'h0;
      goto_wb_r <= 1'b0;
      addr_r    <= 32'h0;
      wdata_r   <= 32'h0;
      wen_r     <= 4'h0;
      store_r   <= 1'b0;
      ltype_r   <= '0;
      vsrc2_r   <= 32'h0;
      result_r  <= 32'h0;
    end else begin
      state <= state_nx;

      // Clear always wins; otherwise an unstalled idle stage takes what
      // execute offers (or empties if execute has nothing).
      if (MEM_clear)
        valid_r <= 1'b0;
      else if (state == IDLE && !MEM_stall)
        valid_r <= EXE_valid;

      if (capture) begin
        pc_r      <= EXE_pc;
        dest_r    <= EXE_dest;
        goto_wb_r <= EXE_goto_WB;
        addr_r    <= EXE_alu_result;
        wdata_r   <= EXE_mem_wdata;
        wen_r     <= EXE_mem_wen;
        store_r   <= EXE_store;
        ltype_r   <= exe_ltype;
        vsrc2_r   <= EXE_vsrc2;
        result_r  <= EXE_alu_result;
      end else if (state == WAIT && dbus.data_data_ok && !MEM_clear && !store_r) begin
        result_r  <= align_result;
      end
    end
  end

  // Next-state logic; a cleared instruction is recognised by valid_r==0
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (capture && (EXE_load || EXE_store) && !EXE_exc_any)
          state_nx = REQ;
      end
      REQ: begin
        if (dbus.data_addr_ok)
          state_nx = (valid_r && !MEM_clear) ? WAIT : CANCEL;
      end
      WAIT: begin
        if (dbus.data_data_ok)
          state_nx = IDLE;
        else if (MEM_clear)
          state_nx = CANCEL;
      end
      CANCEL: begin
        if (dbus.data_data_ok)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bus and write-back outputs driven straight from the captured registers
  always_comb begin
    dbus.data_req   = (state == REQ);
    dbus.data_wr    = store_r;
    dbus.data_wstrb = store_r ? wen_r : 4'h0;
    dbus.data_wdata = wdata_r;
    dbus.data_addr  = (ADDR_MASK_KSEG && is_kseg(addr_r)) ? (addr_r & KSEG_MASK) : addr_r;
    MEM_valid       = valid_r && (state == IDLE);
    MEM_result      = result_r;
    MEM_dest        = dest_r;
    MEM_goto_WB     = goto_wb_r;
    MEM_pc          = pc_r;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage with a randomised memory
//               responder and a behavioural load-alignment reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        MEM_stall, MEM_clear;
  logic        EXE_valid, EXE_load, EXE_store;
  logic        EXE_LB, EXE_LBU, EXE_LH, EXE_LHU, EXE_LW, EXE_LWL, EXE_LWR;
  logic [31:0] EXE_alu_result, EXE_mem_wdata, EXE_vsrc2, EXE_pc;
  logic [3:0]  EXE_mem_wen;
  logic [4:0]  EXE_dest;
  logic        EXE_goto_WB, EXE_exc_any;
  logic        MEM_busy, MEM_valid, MEM_goto_WB;
  logic [31:0] MEM_result, MEM_pc;
  logic [4:0]  MEM_dest;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage_if dbus ();

  always #5 clk = ~clk;

  mem_stage #(.ADDR_MASK_KSEG(1'b1)) dut (
    .clk(clk), .reset(reset), .MEM_stall(MEM_stall), .MEM_clear(MEM_clear),
    .EXE_valid(EXE_valid), .EXE_load(EXE_load), .EXE_store(EXE_store),
    .EXE_LB(EXE_LB), .EXE_LBU(EXE_LBU), .EXE_LH(EXE_LH), .EXE_LHU(EXE_LHU),
    .EXE_LW(EXE_LW), .EXE_LWL(EXE_LWL), .EXE_LWR(EXE_LWR),
    .EXE_alu_result(EXE_alu_result), .EXE_mem_wen(EXE_mem_wen),
    .EXE_mem_wdata(EXE_mem_wdata), .EXE_vsrc2(EXE_vsrc2), .EXE_dest(EXE_dest),
    .EXE_goto_WB(EXE_goto_WB), .EXE_pc(EXE_pc), .EXE_exc_any(EXE_exc_any),
    .dbus(dbus),
    .MEM_busy(MEM_busy), .MEM_valid(MEM_valid), .MEM_result(MEM_result),
    .MEM_dest(MEM_dest), .MEM_goto_WB(MEM_goto_WB), .MEM_pc(MEM_pc)
  );

  // Load kinds: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR
  function automatic logic [31:0] ref_load(input int kind, input logic [31:0] rd,
                                           input logic [31:0] rt, input int a);
    logic [31:0] b, h;
    logic [63:0] t, m;
    b = (rd >> (8 * a)) & 32'hFF;
    h = (rd >> (16 * (a / 2))) & 32'hFFFF;
    case (kind)
      0: return b[7] ? (b | 32'hFFFF_FF00) : b;
      1: return b;
      2: return h[15] ? (h | 32'hFFFF_0000) : h;
      3: return h;
      4: return rd;
      5: begin
        t = {32'h0, rd} << (8 * (3 - a));
        m = 64'hFFFF_FFFF >> (8 * (a + 1));
        return t[31:0] | (rt & m[31:0]);
      end
      default: return (rd >> (8 * a)) | (rt & ~(32'hFFFF_FFFF >> (8 * a)));
    endcase
  endfunction

  function automatic logic [31:0] ref_addr(input logic [31:0] va);
    if (va[31:30] == 2'b10) return va - 32'h8000_0000 - (va[29] ? 32'h2000_0000 : 32'h0);
    return va;
  endfunction

  task automatic drive_idle();
    EXE_valid = 0; EXE_load = 0; EXE_store = 0;
    EXE_LB = 0; EXE_LBU = 0; EXE_LH = 0; EXE_LHU = 0; EXE_LW = 0; EXE_LWL = 0; EXE_LWR = 0;
    EXE_alu_result = 0; EXE_mem_wen = 0; EXE_mem_wdata = 0; EXE_vsrc2 = 0;
    EXE_dest = 0; EXE_goto_WB = 0; EXE_pc = 0; EXE_exc_any = 0;
  endtask

  // Present one instruction for one cycle; returns on the negedge after capture
  task automatic issue(input bit ld, input bit st, input int kind, input logic [31:0] alu,
                       input logic [3:0] wen, input logic [31:0] wd, input logic [31:0] rt,
                       input logic [4:0] dest, input bit gwb, input logic [31:0] pc, input bit exc);
    EXE_valid = 1; EXE_load = ld; EXE_store = st;
    EXE_LB = ld && kind == 0; EXE_LBU = ld && kind == 1; EXE_LH = ld && kind == 2;
    EXE_LHU = ld && kind == 3; EXE_LW = ld && kind == 4; EXE_LWL = ld && kind == 5;
    EXE_LWR = ld && kind == 6;
    EXE_alu_result = alu; EXE_mem_wen = wen; EXE_mem_wdata = wd; EXE_vsrc2 = rt;
    EXE_dest = dest; EXE_goto_WB = gwb; EXE_pc = pc; EXE_exc_any = exc;
    @(negedge clk);
    drive_idle();
  endtask

  // Memory responder: accept after d_addr cycles, respond d_data cycles later
  task automatic serve(input int d_addr, input int d_data, input logic [31:0] rd,
                       output bit got_req, output bit stable, output int busy_n,
                       output logic [31:0] a0, output bit wr0, output logic [3:0] strb0,
                       output logic [31:0] wd0);
    got_req = dbus.data_req; stable = 1; busy_n = 0;
    a0 = dbus.data_addr; wr0 = dbus.data_wr; strb0 = dbus.data_wstrb; wd0 = dbus.data_wdata;
    if (!got_req) return;
    busy_n += int'(MEM_busy);
    repeat (d_addr) begin
      @(negedge clk);
      busy_n += int'(MEM_busy);
      if (!dbus.data_req || dbus.data_addr !== a0 || dbus.data_wr !== wr0 ||
          dbus.data_wstrb !== strb0 || dbus.data_wdata !== wd0) stable = 0;
    end
    dbus.data_addr_ok = 1;
    @(negedge clk);
    dbus.data_addr_ok = 0;
    busy_n += int'(MEM_busy);
    if (dbus.data_req) stable = 0;
    repeat (d_data - 1) begin
      @(negedge clk);
      busy_n += int'(MEM_busy);
    end
    dbus.data_data_ok = 1; dbus.data_rdata = rd;
    @(negedge clk);
    dbus.data_data_ok = 0; dbus.data_rdata = $urandom;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({MEM_busy, MEM_valid, MEM_result, MEM_dest, MEM_goto_WB, MEM_pc} !== '0) begin
      n_err++; $display("FAIL reset_mem_out: got %h want 0",
                        {MEM_busy, MEM_valid, MEM_result, MEM_dest, MEM_goto_WB, MEM_pc});
    end
    n_cmp++;
    if ({dbus.data_req, dbus.data_wr, dbus.data_wstrb, dbus.data_addr, dbus.data_wdata} !== '0) begin
      n_err++; $display("FAIL reset_bus_out: got %h want 0",
                        {dbus.data_req, dbus.data_wr, dbus.data_wstrb, dbus.data_addr, dbus.data_wdata});
    end
    reset = 0;
  endtask

  task automatic test_passthrough();
    issue(0, 0, 0, 32'h1234_5678, 0, 0, 0, 5'd5, 1, 32'hBFC0_0010, 0);
    n_cmp++;
    if ({MEM_valid, MEM_busy, dbus.data_req} !== 3'b100) begin
      n_err++; $display("FAIL pass_flags: got v/b/req=%b want 100", {MEM_valid, MEM_busy, dbus.data_req});
    end
    n_cmp++;
    if ({MEM_result, MEM_dest, MEM_goto_WB, MEM_pc} !== {32'h1234_5678, 5'd5, 1'b1, 32'hBFC0_0010}) begin
      n_err++; $display("FAIL pass_data: got res=%h dest=%0d wb=%b pc=%h want 12345678/5/1/bfc00010",
                        MEM_result, MEM_dest, MEM_goto_WB, MEM_pc);
    end
    // Stall holds the stage even with a new instruction offered
    MEM_stall = 1;
    EXE_valid = 1; EXE_alu_result = 32'h0BAD_0BAD; EXE_dest = 5'd9;
    @(negedge clk);
    n_cmp++;
    if ({MEM_valid, MEM_result, MEM_dest} !== {1'b1, 32'h1234_5678, 5'd5}) begin
      n_err++; $display("FAIL stall_hold: got v=%b res=%h dest=%0d want 1/12345678/5",
                        MEM_valid, MEM_result, MEM_dest);
    end
    MEM_stall = 0;
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] r0, r1;
    r0 = $urandom; r1 = $urandom;
    EXE_valid = 1; EXE_alu_result = r0; EXE_dest = 5'd1; EXE_goto_WB = 1;
    @(negedge clk);
    n_cmp++;
    if ({MEM_valid, MEM_result, MEM_dest} !== {1'b1, r0, 5'd1}) begin
      n_err++; $display("FAIL b2b_first: got v=%b res=%h want 1/%h", MEM_valid, MEM_result, r0);
    end
    EXE_alu_result = r1; EXE_dest = 5'd2;
    @(negedge clk);
    n_cmp++;
    if ({MEM_valid, MEM_result, MEM_dest} !== {1'b1, r1, 5'd2}) begin
      n_err++; $display("FAIL b2b_second: got v=%b res=%h want 1/%h", MEM_valid, MEM_result, r1);
    end
    drive_idle();
    @(negedge clk);
    n_cmp++;
    if (MEM_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_drain: got valid=%b want 0", MEM_valid);
    end
  endtask

  task automatic test_lb_slow();
    bit g, s; int bn; logic [31:0] a0, wd0; bit wr0; logic [3:0] st0;
    issue(1, 0, 0, 32'h8000_0003, 0, 0, 0, 5'd7, 1, 32'h100, 0);
    serve(2, 1, 32'h80FF_0011, g, s, bn, a0, wr0, st0, wd0);
    n_cmp++;
    if (!g || !s || a0 !== 32'h0000_0003) begin
      n_err++; $display("FAIL lb_addr: got req=%b stable=%b addr=%h want 1/1/00000003", g, s, a0);
    end
    n_cmp++;
    if ({MEM_valid, MEM_busy, MEM_result} !== {2'b10, 32'hFFFF_FF80}) begin
      n_err++; $display("FAIL lb_result: got v=%b b=%b res=%h want 1/0/ffffff80", MEM_valid, MEM_busy, MEM_result);
    end
    n_cmp++;
    if (bn !== 4) begin
      n_err++; $display("FAIL lb_latency: got busy cycles %0d want 4", bn);
    end
  endtask

  task automatic test_lwl_lwr();
    bit g, s; int bn; logic [31:0] a0, wd0; bit wr0; logic [3:0] st0;
    issue(1, 0, 5, 32'h0000_2001, 0, 0, 32'h1122_3344, 5'd3, 1, 32'h200, 0);
    serve(0, 1, 32'hAABB_CCDD, g, s, bn, a0, wr0, st0, wd0);
    n_cmp++;
    if (MEM_result !== 32'hCCDD_3344) begin
      n_err++; $display("FAIL lwl_merge: got %h want ccdd3344", MEM_result);
    end
    issue(1, 0, 6, 32'h0000_2001, 0, 0, 32'h1122_3344, 5'd3, 1, 32'h204, 0);
    serve(1, 2, 32'hAABB_CCDD, g, s, bn, a0, wr0, st0, wd0);
    n_cmp++;
    if (MEM_result !== 32'h11AA_BBCC) begin
      n_err++; $display("FAIL lwr_merge: got %h want 11aabbcc", MEM_result);
    end
  endtask

  task automatic test_store();
    bit g, s; int bn; logic [31:0] a0, wd0; bit wr0; logic [3:0] st0;
    issue(0, 1, 0, 32'h0000_1000, 4'hF, 32'hDEAD_BEEF, 0, 5'd0, 0, 32'h300, 0);
    serve(1, 2, 32'h5555_5555, g, s, bn, a0, wr0, st0, wd0);
    n_cmp++;
    if ({g, s, wr0, st0, a0, wd0} !== {3'b111, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF}) begin
      n_err++; $display("FAIL store_bus: got req=%b st=%b wr=%b strb=%h addr=%h wd=%h want 1/1/1/f/00001000/deadbeef",
                        g, s, wr0, st0, a0, wd0);
    end
    n_cmp++;
    if (bn !== 4) begin
      n_err++; $display("FAIL store_latency: got busy cycles %0d want 4", bn);
    end
    n_cmp++;
    if ({MEM_valid, MEM_busy, MEM_goto_WB, MEM_result} !== {3'b100, 32'h0000_1000}) begin
      n_err++; $display("FAIL store_done: got v=%b b=%b wb=%b res=%h want 1/0/0/00001000",
                        MEM_valid, MEM_busy, MEM_goto_WB, MEM_result);
    end
  endtask

  task automatic test_flush_req();
    bit saw_valid = 0;
    issue(1, 0, 4, 32'h0000_4000, 0, 0, 0, 5'd4, 1, 32'h400, 0);
    MEM_clear = 1;
    @(negedge clk);
    MEM_clear = 0;
    saw_valid |= MEM_valid;
    n_cmp++;
    if ({dbus.data_req, MEM_busy} !== 2'b11) begin
      n_err++; $display("FAIL flush_req_held: got req/busy=%b want 11", {dbus.data_req, MEM_busy});
    end
    @(negedge clk);
    saw_valid |= MEM_valid;
    dbus.data_addr_ok = 1;
    @(negedge clk);
    dbus.data_addr_ok = 0;
    saw_valid |= MEM_valid;
    @(negedge clk);
    saw_valid |= MEM_valid;
    n_cmp++;
    if ({dbus.data_req, MEM_busy} !== 2'b01) begin
      n_err++; $display("FAIL flush_cancel_wait: got req/busy=%b want 01", {dbus.data_req, MEM_busy});
    end
    dbus.data_data_ok = 1; dbus.data_rdata = 32'hFACE_FACE;
    @(negedge clk);
    dbus.data_data_ok = 0;
    saw_valid |= MEM_valid;
    n_cmp++;
    if ({MEM_busy, saw_valid} !== 2'b00) begin
      n_err++; $display("FAIL flush_done: got busy=%b saw_valid=%b want 0/0", MEM_busy, saw_valid);
    end
  endtask

  task automatic test_exc();
    issue(1, 0, 4, 32'h0000_0102, 0, 0, 0, 5'd6, 1, 32'h500, 1);
    n_cmp++;
    if ({dbus.data_req, MEM_busy, MEM_valid, MEM_result} !== {3'b001, 32'h0000_0102}) begin
      n_err++; $display("FAIL exc_suppress: got req=%b b=%b v=%b res=%h want 0/0/1/00000102",
                        dbus.data_req, MEM_busy, MEM_valid, MEM_result);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_wait();
    issue(1, 0, 4, 32'h0000_0100, 0, 0, 0, 5'd8, 1, 32'h600, 0);
    dbus.data_addr_ok = 1;
    @(negedge clk);
    dbus.data_addr_ok = 0;
    n_cmp++;
    if ({dbus.data_req, MEM_busy} !== 2'b01) begin
      n_err++; $display("FAIL rstw_in_wait: got req/busy=%b want 01", {dbus.data_req, MEM_busy});
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    n_cmp++;
    if ({MEM_busy, MEM_valid, MEM_result, MEM_dest, MEM_goto_WB, MEM_pc,
         dbus.data_req, dbus.data_wr, dbus.data_wstrb, dbus.data_addr, dbus.data_wdata} !== '0) begin
      n_err++; $display("FAIL rstw_outputs: got res=%h pc=%h busy=%b addr=%h want all 0",
                        MEM_result, MEM_pc, MEM_busy, dbus.data_addr);
    end
    dbus.data_data_ok = 1; dbus.data_rdata = 32'h7777_7777;
    @(negedge clk);
    dbus.data_data_ok = 0;
    n_cmp++;
    if ({MEM_busy, MEM_valid, MEM_result} !== '0) begin
      n_err++; $display("FAIL rstw_late_ok: got b=%b v=%b res=%h want 0/0/0", MEM_busy, MEM_valid, MEM_result);
    end
  endtask

  task automatic test_random_loads();
    bit g, s; int bn; logic [31:0] a0, wd0; bit wr0; logic [3:0] st0;
    for (int i = 0; i < 24; i++) begin
      int kind, a, da, dd;
      logic [31:0] va, rd, rt, pc, exp;
      logic [4:0] dst;
      kind = int'($urandom_range(0, 6));
      a = int'($urandom_range(0, 3));
      if (kind == 2 || kind == 3) a = a & 2;
      if (kind == 4) a = 0;
      va = ($urandom & 32'hFFFF_FFFC) | a;
      rd = $urandom; rt = $urandom; pc = $urandom; dst = 5'($urandom);
      da = int'($urandom_range(0, 3)); dd = int'($urandom_range(1, 3));
      exp = ref_load(kind, rd, rt, a);
      issue(1, 0, kind, va, 0, 0, rt, dst, 1, pc, 0);
      serve(da, dd, rd, g, s, bn, a0, wr0, st0, wd0);
      n_cmp++;
      if ({g, s, wr0, st0} !== 7'b1100000 || a0 !== ref_addr(va)) begin
        n_err++; $display("FAIL rnd_bus[%0d]: got req=%b st=%b wr=%b strb=%h addr=%h want 1/1/0/0/%h",
                          i, g, s, wr0, st0, a0, ref_addr(va));
      end
      n_cmp++;
      if (bn !== 1 + da + dd) begin
        n_err++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, bn, 1 + da + dd);
      end
      n_cmp++;
      if ({MEM_valid, MEM_busy, MEM_result, MEM_dest, MEM_pc} !== {2'b10, exp, dst, pc}) begin
        n_err++; $display("FAIL rnd_result[%0d] kind=%0d a=%0d: got v=%b b=%b res=%h dest=%0d pc=%h want 1/0/%h/%0d/%h",
                          i, kind, a, MEM_valid, MEM_busy, MEM_result, MEM_dest, MEM_pc, exp, dst, pc);
      end
    end
  endtask

  initial begin
    reset = 1; MEM_stall = 0; MEM_clear = 0;
    drive_idle();
    dbus.data_addr_ok = 0; dbus.data_data_ok = 0; dbus.data_rdata = 0;
    @(negedge clk);
    test_reset();
    test_passthrough();
    test_back_to_back();
    test_lb_slow();
    test_lwl_lwr();
    test_store();
    test_flush_req();
    test_exc();
    test_random_loads();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time limit so the run can never hang
  initial begin
    #200000;
    $display("FAIL timeout: got no completion want finish before limit");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
